// File: rtl/system_cpu_oci_pkg.sv
// Shared constants and state encoding for the on-chip-instrumentation trace packer.
package system_cpu_oci_pkg;

  localparam int DCT_W             = 30;
  localparam int DCT_CNT_W         = 4;
  localparam int DEF_SYM_W         = 3;
  localparam int DEF_SYMS_PER_WORD = 10;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ENDING = 2'd1,
    ST_ENDED  = 2'd2
  } dct_state_e;

endpackage

// File: rtl/system_cpu_oci_dct_packer.sv
// Packs narrow trace symbols into 30-bit words, newest symbol in the low bits.
// Handshake: sym_valid marks a symbol on sym_data; there is no ready, every
// offered symbol is taken on the rising edge (except after capture has ended).
// dct_valid is a one-cycle strobe; dct_buffer/dct_count hold between strobes.
module system_cpu_oci_dct_packer
  import system_cpu_oci_pkg::*;
#(
  parameter int SYM_W         = DEF_SYM_W,
  parameter int SYMS_PER_WORD = DEF_SYMS_PER_WORD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sym_valid,
  input  logic [SYM_W-1:0]     sym_data,
  input  logic                 flush,
  input  logic                 end_req,
  output logic [DCT_W-1:0]     dct_buffer,
  output logic [DCT_CNT_W-1:0] dct_count,
  output logic                 dct_valid,
  output logic                 test_ending,
  output logic                 test_has_ended,
  output logic [1:0]           state_dbg
);

  localparam logic [DCT_CNT_W-1:0] FULL_CNT = DCT_CNT_W'(SYMS_PER_WORD);

  dct_state_e           state;
  logic [DCT_W-1:0]     acc;
  logic [DCT_CNT_W-1:0] cnt;

  logic                 take;
  logic                 flush_now;
  logic                 emit;
  logic [DCT_W-1:0]     acc_nx;
  logic [DCT_CNT_W-1:0] cnt_nx;

  assign state_dbg = state;

  // Next accumulator contents including this cycle's symbol, and whether a word goes out.
  always_comb begin
    take      = 1'b0;
    flush_now = 1'b0;
    emit      = 1'b0;
    acc_nx    = acc;
    cnt_nx    = cnt;
    take      = sym_valid && (state != ST_ENDED);
    if (take) begin
      acc_nx = {acc[DCT_W-1-SYM_W:0], sym_data};
      cnt_nx = cnt + 1'b1;
    end
    // ENDING always behaves as a flush; flush input is ignored once ended.
    flush_now = (flush && (state == ST_RUN)) || (state == ST_ENDING);
    // A full word and a coinciding flush produce one and the same emission.
    emit      = (cnt_nx == FULL_CNT) || (flush_now && (cnt_nx != '0));
  end

  // Accumulator, output word registers and the capture-end FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_RUN;
      acc            <= '0;
      cnt            <= '0;
      dct_buffer     <= '0;
      dct_count      <= '0;
      dct_valid      <= 1'b0;
      test_ending    <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      dct_valid <= emit;
      if (emit) begin
        // acc is cleared after each word, so a partial word is already right-justified.
        dct_buffer <= acc_nx;
        dct_count  <= cnt_nx;
        acc        <= '0;
        cnt        <= '0;
      end else begin
        acc <= acc_nx;
        cnt <= cnt_nx;
      end
      case (state)
        ST_RUN: begin
          if (end_req) begin
            state       <= ST_ENDING;
            test_ending <= 1'b1;
          end
        end
        ST_ENDING: begin
          state          <= ST_ENDED;
          test_has_ended <= 1'b1;
        end
        default: state <= ST_ENDED;
      endcase
    end
  end

endmodule

// File: doc/system_cpu_oci_dct_packer.md
SYSTEM_CPU_OCI_DCT_PACKER -- requirements
Module: system_cpu_oci_dct_packer

Interface
REQ-001 Parameter SYM_W, default 3, trace symbol width in bits.
REQ-002 Parameter SYMS_PER_WORD, default 10, symbols per packed word; SYM_W*SYMS_PER_WORD SHALL equal 30.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sym_valid  input  1  a trace symbol is offered this cycle; always accepted, no back-pressure.
REQ-006 sym_data  input  SYM_W  trace symbol value.
REQ-007 flush  input  1  emit any partially filled word.
REQ-008 end_req  input  1  request end of trace capture.
REQ-009 dct_buffer  output  30  packed word, newest symbol in bits [SYM_W-1:0].
REQ-010 dct_count  output  4  number of valid symbols in dct_buffer, 0..SYMS_PER_WORD.
REQ-011 dct_valid  output  1  one-cycle strobe: dct_buffer/dct_count carry a new word.
REQ-012 test_ending  output  1  capture is ending; sticky until reset.
REQ-013 test_has_ended  output  1  final word emitted; sticky until reset.

Function
REQ-014 Internal accumulator acc (30 bits) and fill counter cnt (0..SYMS_PER_WORD); on an accepted symbol acc SHALL become {acc[29-SYM_W:0], sym_data} and cnt SHALL increment.
REQ-015 Every output SHALL be registered; dct_buffer and dct_count SHALL hold their last emitted value between strobes.
REQ-016 On the edge that accepts the SYMS_PER_WORD-th symbol, the block SHALL load dct_buffer with the full acc, dct_count with SYMS_PER_WORD, pulse dct_valid, and clear acc and cnt to 0 (zero latency beyond the register).
REQ-017 flush with cnt>0 (counting any symbol accepted the same cycle) SHALL emit the word right-justified, unused upper bits zero, dct_count = fill, then clear acc and cnt.
REQ-018 flush with cnt=0 and no symbol that cycle SHALL emit nothing; dct_valid stays 0.
REQ-019 flush coinciding with the SYMS_PER_WORD-th symbol SHALL produce exactly one word with count SYMS_PER_WORD.
REQ-020 FSM states RUN, ENDING, ENDED; reset state RUN.
REQ-021 RUN -> ENDING on end_req; symbols still accepted in RUN and in the ENDING cycle.
REQ-022 ENDING lasts one cycle: forced flush (REQ-017/018 rules), then -> ENDED.
REQ-023 test_ending SHALL be 1 in ENDING and ENDED; test_has_ended SHALL be 1 in ENDED, rising on the same edge as the final dct_valid (if any).
REQ-024 In ENDED, sym_valid, flush and end_req SHALL be ignored; no further dct_valid.
REQ-025 end_req in ENDING or ENDED SHALL have no effect.

Reset
REQ-026 reset SHALL asynchronously clear acc, cnt, dct_buffer, dct_count, dct_valid, test_ending and test_has_ended to 0 and force state RUN.
REQ-027 reset mid-word SHALL discard the partial word without emitting it.

Structure
REQ-028 Shared package system_cpu_oci_pkg SHALL hold DCT_W=30, DCT_CNT_W=4, the default symbol constants and the FSM state enum.
REQ-029 Single module; no sub-module required.

Verification
REQ-030 Symbols 1,2,3,4,5,6,7,0,1,2 on consecutive cycles -> one dct_valid on the 10th accept edge, dct_buffer=30'o1234567012, dct_count=10.
REQ-031 Symbols 5,6,7 then flush -> dct_buffer=30'o567, dct_count=3, one strobe; second flush -> no strobe.
REQ-032 Nine symbols of 7, then 10th symbol 7 with flush same cycle -> single strobe, dct_buffer=30'o7777777777, dct_count=10.
REQ-033 Four symbols 3 then end_req -> test_ending=1 next cycle; following edge dct_buffer=30'o3333, dct_count=4, dct_valid=1, test_has_ended=1; later symbols produce no strobe.
REQ-034 Five symbols then reset asserted mid-cycle -> all outputs 0 immediately; after release, ten symbols of 1 -> dct_buffer=30'o1111111111, dct_count=10.
